rot_cmd_seq: RTL and testbench
==============================

ROT_CMD_SEQ -- requirements
Module: rot_cmd_seq

Interface
REQ-001 Parameter DW, default 4, rotate data width; SHALL be a power of two, >= 2.
REQ-002 Parameter AW, default 2, rotate-amount width; SHALL equal clog2(DW).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 sync_rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted on posedge when cmd_valid & cmd_ready.
REQ-007 cmd_load  input  1  1 = issue one load step with cmd_data before rotating.
REQ-008 cmd_dir  input  1  0 = rotate right (bit i takes bit i+1, MSB takes bit 0); 1 = rotate left (bit i takes bit i-1, bit 0 takes MSB).
REQ-009 cmd_amt  input  AW  number of rotate steps, 0..DW-1.
REQ-010 cmd_data  input  DW  load value.
REQ-011 rot_ctrl  output  2  drives the rotate register ctrl: 00 load, 01 right, 10 left, 11 hold.
REQ-012 rot_data  output  DW  drives the rotate register data input.
REQ-013 done  output  1  one-cycle pulse: command complete, register holds result.

Function
REQ-014 States SHALL be IDLE, LOAD, ROT, DONE; rot_ctrl, rot_data and done SHALL be registered.
REQ-015 Acceptance in IDLE SHALL latch dir, amt and data, then go to LOAD if cmd_load=1, else ROT if cmd_amt!=0, else DONE.
REQ-016 LOAD SHALL last exactly one cycle with rot_ctrl=00 and rot_data=latched data; exit to ROT if amt!=0, else DONE.
REQ-017 ROT SHALL last exactly amt cycles with rot_ctrl=01 (dir 0) or 10 (dir 1), decrementing a step counter each cycle.
REQ-018 DONE SHALL last one cycle with rot_ctrl=11 and done=1, then go to IDLE.
REQ-019 In IDLE and DONE rot_ctrl SHALL be 11; rot_data SHALL keep its last value outside LOAD.
REQ-020 Latency: for a command accepted at edge T, done SHALL be high in cycle T+1+L+amt (L = cmd_load).
REQ-021 cmd_load=0, cmd_amt=0 SHALL go directly to DONE: one done pulse, no non-hold ctrl.
REQ-022 cmd_* SHALL be ignored unless cmd_valid & cmd_ready; cmd_valid during a busy sequence SHALL NOT alter it.
REQ-023 The block SHALL NOT observe the register contents; wrap-around is implied by the rotate encoding.

Reset
REQ-024 sync_rst=1 at a posedge SHALL force IDLE, rot_ctrl=11, rot_data=0, done=0, step counter=0, buffer empty.
REQ-025 cmd_ready SHALL be 0 while sync_rst=1; no command is accepted in that cycle.
REQ-026 Reset mid-sequence SHALL abandon the command with no done pulse.

Configuration
REQ-027 Macro ROT_SEQ_CMD_BUF_EN SHALL add a one-entry command buffer.
REQ-028 With it defined: cmd_ready = ~buf_full & ~sync_rst in any state; DONE with buffer full SHALL go straight to LOAD/ROT/DONE per REQ-015 using the buffered command (no IDLE cycle); acceptance in IDLE with empty buffer SHALL bypass the buffer.
REQ-029 Without it: cmd_ready = (state==IDLE) & ~sync_rst, no buffer logic.

Structure
REQ-030 Package rot_pkg SHALL hold the rot_ctrl constants ROT_LOAD, ROT_RIGHT, ROT_LEFT, ROT_HOLD and the state enum type.
REQ-031 The buffer SHALL be sub-module rot_cmd_buf, instantiated only under ROT_SEQ_CMD_BUF_EN.

Verification (DW=4; bench instantiates the existing universal rotate register driven by rot_ctrl/rot_data, same clk/sync_rst)
REQ-032 load=1, data=1001, dir=0, amt=1 -> rot_ctrl 00,01,11; done at T+3; q=1100.
REQ-033 Next: load=0, dir=1, amt=3 -> rot_ctrl 10,10,10,11; done at T+4; q sequence 1001,0011,0110.
REQ-034 load=0, amt=0 -> done at T+1, rot_ctrl stays 11, q unchanged.
REQ-035 sync_rst during ROT step 2 of amt=3 -> next cycle IDLE, rot_ctrl=11, no done, cmd_ready=1 the cycle after reset drops.
REQ-036 Back-to-back with ROT_SEQ_CMD_BUF_EN: second command accepted while busy -> its first step in the cycle after the first done; without macro cmd_ready=0 until IDLE.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared definitions for the rotate-register command sequencer: the rot_ctrl
// encodings understood by the universal rotate register and the FSM state type.
package rot_pkg;

    localparam logic [1:0] ROT_LOAD  = 2'b00;
    localparam logic [1:0] ROT_RIGHT = 2'b01;
    localparam logic [1:0] ROT_LEFT  = 2'b10;
    localparam logic [1:0] ROT_HOLD  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRot,
        StDone
    } state_e;

endpackage

// File: rtl/rot_cmd_buf.sv
// One-entry command holding register. Lets the sequencer accept the next
// command while it is still busy with the current one. Used only when
// ROT_SEQ_CMD_BUF_EN is defined. Push and pop never coincide, because a push
// needs an empty entry and a pop needs a full one.
module rot_cmd_buf #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          push,
    input  logic          pop,
    input  logic          in_load,
    input  logic          in_dir,
    input  logic [AW-1:0] in_amt,
    input  logic [DW-1:0] in_data,
    output logic          full,
    output logic          out_load,
    output logic          out_dir,
    output logic [AW-1:0] out_amt,
    output logic [DW-1:0] out_data
);

    logic          full_q, full_d;
    logic          load_q, load_d;
    logic          dir_q, dir_d;
    logic [AW-1:0] amt_q, amt_d;
    logic [DW-1:0] data_q, data_d;

    // Next-state for the occupancy flag and the stored command.
    always_comb begin
        full_d = full_q;
        load_d = load_q;
        dir_d  = dir_q;
        amt_d  = amt_q;
        data_d = data_q;
        if (pop) begin
            full_d = 1'b0;
        end
        if (push) begin
            full_d = 1'b1;
            load_d = in_load;
            dir_d  = in_dir;
            amt_d  = in_amt;
            data_d = in_data;
        end
    end

    // Entry register with synchronous reset to empty.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            full_q <= 1'b0;
            load_q <= 1'b0;
            dir_q  <= 1'b0;
            amt_q  <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            load_q <= load_d;
            dir_q  <= dir_d;
            amt_q  <= amt_d;
            data_q <= data_d;
        end
    end

    assign full     = full_q;
    assign out_load = load_q;
    assign out_dir  = dir_q;
    assign out_amt  = amt_q;
    assign out_data = data_q;

endmodule

// File: rtl/rot_cmd_seq.sv
// Command sequencer for a universal rotate register. Each accepted command
// becomes an optional load step, then amt rotate steps, then a one-cycle
// done pulse. rot_ctrl, rot_data and done are registered, so they always
// describe the state being entered.
// Optional feature: define ROT_SEQ_CMD_BUF_EN to add a one-entry command
// buffer, so a command can be accepted while a sequence is running.
module rot_cmd_seq
    import rot_pkg::*;
#(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic          cmd_dir,
    input  logic [AW-1:0] cmd_amt,
    input  logic [DW-1:0] cmd_data,
    output logic [1:0]    rot_ctrl,
    output logic [DW-1:0] rot_data,
    output logic          done
);

    state_e        state_q, state_d;
    logic          dir_q, dir_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic [1:0]    rot_ctrl_q, rot_ctrl_d;
    logic [DW-1:0] rot_data_q, rot_data_d;
    logic          done_q, done_d;

    // Command that starts a new sequence this cycle, whether it comes from the port or the buffer.
    logic          accept;
    logic          start;
    logic          st_load;
    logic          st_dir;
    logic [AW-1:0] st_amt;
    logic [DW-1:0] st_data;

`ifdef ROT_SEQ_CMD_BUF_EN
    logic          buf_full;
    logic          buf_push;
    logic          buf_pop;
    logic          buf_load;
    logic          buf_dir;
    logic [AW-1:0] buf_amt;
    logic [DW-1:0] buf_data;

    assign cmd_ready = ~buf_full & ~sync_rst;
    assign accept    = cmd_valid & cmd_ready;
    // A command taken in IDLE starts at once. Any other accepted command waits in the buffer.
    assign buf_push  = accept & (state_q != StIdle);

    // A buffered command has priority and starts from DONE (or IDLE) without an idle gap.
    always_comb begin
        buf_pop = 1'b0;
        start   = 1'b0;
        st_load = cmd_load;
        st_dir  = cmd_dir;
        st_amt  = cmd_amt;
        st_data = cmd_data;
        if (buf_full && (state_q == StIdle || state_q == StDone)) begin
            buf_pop = 1'b1;
            start   = 1'b1;
            st_load = buf_load;
            st_dir  = buf_dir;
            st_amt  = buf_amt;
            st_data = buf_data;
        end else if (accept && state_q == StIdle) begin
            start = 1'b1;
        end
    end

    rot_cmd_buf #(
        .DW(DW),
        .AW(AW)
    ) u_cmd_buf (
        .clk      (clk),
        .sync_rst (sync_rst),
        .push     (buf_push),
        .pop      (buf_pop),
        .in_load  (cmd_load),
        .in_dir   (cmd_dir),
        .in_amt   (cmd_amt),
        .in_data  (cmd_data),
        .full     (buf_full),
        .out_load (buf_load),
        .out_dir  (buf_dir),
        .out_amt  (buf_amt),
        .out_data (buf_data)
    );
`else
    assign cmd_ready = (state_q == StIdle) & ~sync_rst;
    assign accept    = cmd_valid & cmd_ready;
    assign start     = accept;
    assign st_load   = cmd_load;
    assign st_dir    = cmd_dir;
    assign st_amt    = cmd_amt;
    assign st_data   = cmd_data;
`endif

    // Next-state, step counter and registered-output values for the state being entered.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: state_d = StIdle;
            StLoad: state_d = (cnt_q != '0) ? StRot : StDone;
            StRot: begin
                cnt_d   = cnt_q - AW'(1);
                state_d = (cnt_q == AW'(1)) ? StDone : StRot;
            end
            StDone: state_d = StIdle;
        endcase
        if (start) begin
            dir_d  = st_dir;
            cnt_d  = st_amt;
            data_d = st_data;
            if (st_load) begin
                state_d = StLoad;
            end else if (st_amt != '0) begin
                state_d = StRot;
            end else begin
                state_d = StDone;
            end
        end

        rot_data_d = rot_data_q;
        rot_ctrl_d = ROT_HOLD;
        unique case (state_d)
            StLoad: begin
                rot_ctrl_d = ROT_LOAD;
                rot_data_d = data_d;
            end
            StRot:  rot_ctrl_d = dir_d ? ROT_LEFT : ROT_RIGHT;
            StIdle: rot_ctrl_d = ROT_HOLD;
            StDone: rot_ctrl_d = ROT_HOLD;
        endcase
        done_d = (state_d == StDone);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q    <= StIdle;
            dir_q      <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            rot_ctrl_q <= ROT_HOLD;
            rot_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rot_ctrl_q <= rot_ctrl_d;
            rot_data_q <= rot_data_d;
            done_q     <= done_d;
        end
    end

    assign rot_ctrl = rot_ctrl_q;
    assign rot_data = rot_data_q;
    assign done     = done_q;

endmodule

// File: tb/tb_rot_cmd_seq.sv
// Self-checking bench for rot_cmd_seq. A rotate register driven by rot_ctrl
// and rot_data sits beside the DUT. The reference keeps a queue of expected
// per-cycle outputs, built from each accepted command. Build with
// ROT_SEQ_CMD_BUF_EN defined to check the buffered variant.
module tb_rot_cmd_seq;

    localparam int DW = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          sync_rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_load = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [AW-1:0] cmd_amt = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [1:0]    rot_ctrl;
    logic [DW-1:0] rot_data;
    logic          done;
    logic [DW-1:0] rr_q;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] ctrl;
        bit         dn;
        bit         first;
        int         data;
        int         qv;
    } ent_t;

    ent_t exp_q[$];
    int   model_v = 0;
    int   exp_rd  = 0;

    rot_cmd_seq #(
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_dir   (cmd_dir),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .rot_ctrl  (rot_ctrl),
        .rot_data  (rot_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Universal rotate register controlled by the sequencer.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            rr_q <= '0;
        end else begin
            case (rot_ctrl)
                2'b00:   rr_q <= rot_data;
                2'b01:   rr_q <= {rr_q[0], rr_q[DW-1:1]};
                2'b10:   rr_q <= {rr_q[DW-2:0], rr_q[DW-1]};
                default: rr_q <= rr_q;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rot_model(input int v, input bit dir, input int n);
        int m;
        m = (1 << DW) - 1;
        if (n == 0) return v;
        if (!dir) return ((v >> n) | (v << (DW - n))) & m;
        return ((v << n) | (v >> (DW - n))) & m;
    endfunction

    // Appends the expected cycles of one command. gap adds a hold cycle first.
    function automatic void push_cmd(input bit ld, input bit dr, input int am, input int dt,
                                     input bit gap);
        ent_t e;
        bit   first;
        first = 1'b1;
        if (gap) begin
            e = '{ctrl: 2'b11, dn: 1'b0, first: 1'b0, data: 0, qv: 0};
            exp_q.push_back(e);
        end
        if (ld) begin
            e = '{ctrl: 2'b00, dn: 1'b0, first: first, data: dt, qv: 0};
            exp_q.push_back(e);
            first   = 1'b0;
            model_v = dt;
        end
        for (int i = 0; i < am; i++) begin
            e = '{ctrl: (dr ? 2'b10 : 2'b01), dn: 1'b0, first: first, data: 0, qv: 0};
            exp_q.push_back(e);
            first = 1'b0;
        end
        model_v = rot_model(model_v, dr, am);
        e = '{ctrl: 2'b11, dn: 1'b1, first: first, data: 0, qv: model_v};
        exp_q.push_back(e);
    endfunction

    // One clock cycle: check this cycle's outputs, then drive the inputs for the next edge.
    task automatic step(input bit v, input bit ld, input bit dr, input int am, input int dt,
                        input bit rs);
        ent_t cur;
        bit   busy;
        bit   full;
        bit   exp_ready;
        @(negedge clk);
        busy = (exp_q.size() > 0);
        if (busy) cur = exp_q.pop_front();
        else cur = '{ctrl: 2'b11, dn: 1'b0, first: 1'b0, data: 0, qv: 0};
        if (cur.ctrl == 2'b00) exp_rd = cur.data;
        check_eq("rot_ctrl", 32'(rot_ctrl), 32'(cur.ctrl));
        check_eq("done", 32'(done), 32'(cur.dn));
        check_eq("rot_data", 32'(rot_data), 32'(exp_rd));
        if (cur.dn) check_eq("reg_q", 32'(rr_q), 32'(cur.qv));

        sync_rst  = rs;
        cmd_valid = v;
        cmd_load  = ld;
        cmd_dir   = dr;
        cmd_amt   = AW'(am);
        cmd_data  = DW'(dt);
        #1;
        full = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].first) full = 1'b1;
`ifdef ROT_SEQ_CMD_BUF_EN
        exp_ready = !rs && !full;
`else
        exp_ready = !rs && !busy;
`endif
        check_eq("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        if (rs) begin
            exp_q.delete();
            model_v = 0;
            exp_rd  = 0;
        end else if (v && exp_ready) begin
            // A command taken during DONE sits in the buffer through one IDLE cycle.
            push_cmd(ld, dr, am, dt, busy && cur.dn);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        // Reset state.
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        check_eq("reset_q", 32'(rr_q), 32'h0);

        // Load 1001, one right rotate.
        step(1'b1, 1'b1, 1'b0, 1, 4'b1001, 1'b0);
        idle(4);
        check_eq("load_rot_right_q", 32'(rr_q), 32'hC);

        // Three left rotates, no load.
        step(1'b1, 1'b0, 1'b1, 3, 0, 1'b0);
        idle(5);
        check_eq("rot_left3_q", 32'(rr_q), 32'h6);

        // Zero-length command: only a done pulse.
        step(1'b1, 1'b0, 1'b0, 0, 4'hF, 1'b0);
        idle(2);
        check_eq("amt0_q", 32'(rr_q), 32'h6);

        // Reset during the second rotate step, with a command offered in the reset cycle.
        step(1'b1, 1'b0, 1'b0, 3, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 2, 4'h3, 1'b1);
        idle(3);

        // Back-to-back offers while busy.
        step(1'b1, 1'b1, 1'b0, 2, 4'h5, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 3, 4'hA, 1'b0);
        idle(12);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15),
                 ($urandom_range(0, 59) == 0));
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
